// File: rtl/pcpi_link_pkg.sv
// Constants and FSM state type shared by the host transmitter and the
// PCPI coprocessor tile's nibble receiver.
package pcpi_link_pkg;

  localparam int unsigned INSN_W   = 32;
  localparam int unsigned NIBBLE_W = 4;
  localparam int unsigned NIBBLES  = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_RELEASE,
    ST_GAP
  } link_state_e;

endpackage

// File: rtl/nibble_insn_tx.sv
// Host-side serialiser: sends a 32-bit instruction word as eight nibbles,
// LSB nibble first, using a send/ack handshake with the coprocessor tile.
module nibble_insn_tx
  import pcpi_link_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 64,
  parameter int unsigned GAP_CYCLES  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                word_valid,
  input  logic [INSN_W-1:0]   word_data,
  output logic                word_ready,
  output logic [NIBBLE_W-1:0] seg_out,
  output logic                send_out,
  input  logic                ack_in,
  output logic                busy,
  output logic                done,
  output logic                timeout_err
);

  localparam int unsigned         IDX_W    = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(NIBBLES - 1);
  localparam logic [31:0]         TO_LAST  = 32'(ACK_TIMEOUT - 1);
  localparam logic [31:0]         GAP_LAST = 32'(GAP_CYCLES - 1);

  link_state_e         state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [INSN_W-1:0]   word_q, word_d;
  logic [31:0]         to_cnt_q, to_cnt_d;
  logic [31:0]         gap_cnt_q, gap_cnt_d;
  logic                done_q, done_d;
  logic                terr_q, terr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      word_q    <= '0;
      to_cnt_q  <= '0;
      gap_cnt_q <= '0;
      done_q    <= 1'b0;
      terr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      word_q    <= word_d;
      to_cnt_q  <= to_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      done_q    <= done_d;
      terr_q    <= terr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    word_d    = word_q;
    to_cnt_d  = to_cnt_q;
    gap_cnt_d = gap_cnt_q;
    done_d    = 1'b0;
    terr_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (word_valid) begin
          word_d   = word_data;
          idx_d    = '0;
          to_cnt_d = '0;
          state_d  = ST_SEND;
        end
      end
      ST_SEND: begin
        // ack is checked before the timeout so a same-cycle ack wins
        if (ack_in) begin
          if (idx_q == IDX_LAST) begin
            gap_cnt_d = '0;
            done_d    = 1'b1;
            state_d   = ST_GAP;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_RELEASE;
          end
        end else if ((ACK_TIMEOUT != 0) && (to_cnt_q == TO_LAST)) begin
          terr_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 32'd1;
        end
      end
      ST_RELEASE: begin
        to_cnt_d = '0;
        state_d  = ST_SEND;
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 32'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    word_ready  = (state_q == ST_IDLE);
    busy        = (state_q != ST_IDLE);
    send_out    = (state_q == ST_SEND);
    seg_out     = '0;
    if (state_q == ST_SEND) begin
      seg_out = word_q[NIBBLE_W*idx_q +: NIBBLE_W];
    end
    done        = done_q;
    timeout_err = terr_q;
  end

endmodule

// File: tb/tb_nibble_insn_tx.sv
// Directed bench for nibble_insn_tx with a behavioural loopback receiver
// that latches each nibble and answers with a one-cycle ack.
module tb_nibble_insn_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        word_valid;
  logic [31:0] word_data;
  logic        word_ready;
  logic [3:0]  seg_out;
  logic        send_out;
  logic        ack_in;
  logic        busy;
  logic        done;
  logic        timeout_err;

  logic        resp_en;
  logic        force_ack;
  logic        ack_r;
  logic [31:0] rx_word;

  int nchecks = 0;
  int nerr    = 0;

  logic [3:0] seg_log  [0:63];
  logic       send_log [0:63];
  logic       done_log [0:63];
  logic       rdy_log  [0:63];
  logic [3:0] exp_nib  [0:7];

  always #5 clk = ~clk;

  nibble_insn_tx #(
    .ACK_TIMEOUT(64),
    .GAP_CYCLES (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .word_valid (word_valid),
    .word_data  (word_data),
    .word_ready (word_ready),
    .seg_out    (seg_out),
    .send_out   (send_out),
    .ack_in     (ack_in),
    .busy       (busy),
    .done       (done),
    .timeout_err(timeout_err)
  );

  // Receiver model: latch on the first send cycle, ack on the next
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_r   <= 1'b0;
      rx_word <= '0;
    end else begin
      ack_r <= send_out && !ack_r;
      if (resp_en && send_out && !ack_r) rx_word <= {seg_out, rx_word[31:4]};
    end
  end

  assign ack_in = (resp_en && ack_r) || force_ack;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    int dcnt;
    int scnt;
    exp_nib[0] = 4'h8; exp_nib[1] = 4'h7; exp_nib[2] = 4'h6; exp_nib[3] = 4'h5;
    exp_nib[4] = 4'h4; exp_nib[5] = 4'h3; exp_nib[6] = 4'h2; exp_nib[7] = 4'h1;
    rst_n = 1'b0; word_valid = 1'b0; word_data = '0; resp_en = 1'b1; force_ack = 1'b0;

    #1;
    chk("rst_send", send_out, 1'b0);
    chk("rst_seg", seg_out, 4'h0);
    chk("rst_done", done, 1'b0);
    chk("rst_terr", timeout_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", word_ready, 1'b1);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Single word in loopback
    word_data = 32'h12345678; word_valid = 1'b1;
    chk("t1_ready0", word_ready, 1'b1);
    tick();
    word_valid = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      seg_log[c] = seg_out; send_log[c] = send_out; done_log[c] = done; rdy_log[c] = word_ready;
      tick();
    end
    for (int k = 0; k < 8; k++) begin
      chk("t1_seg", {28'd0, seg_log[1+3*k]}, {28'd0, exp_nib[k]});
      chk("t1_seg_dwell", {28'd0, seg_log[2+3*k]}, {28'd0, exp_nib[k]});
      chk("t1_send", send_log[1+3*k], 1'b1);
      if (k < 7) chk("t1_release", send_log[3+3*k], 1'b0);
    end
    dcnt = 0;
    for (int c = 1; c <= 40; c++) dcnt += done_log[c];
    chk("t1_done24", done_log[24], 1'b1);
    chk("t1_done_count", dcnt, 1);
    chk("t1_ready39", rdy_log[39], 1'b0);
    chk("t1_ready40", rdy_log[40], 1'b1);
    chk("t1_rx", rx_word, 32'h12345678);

    // Back-to-back with word_valid held high
    word_data = 32'hDEADBEEF; word_valid = 1'b1;
    tick();
    word_data = 32'h0000000F;
    for (int c = 1; c <= 40; c++) begin
      send_log[c] = send_out; rdy_log[c] = word_ready;
      tick();
    end
    scnt = 0;
    for (int c = 24; c <= 39; c++) scnt += send_log[c];
    chk("t2_gap_quiet", scnt, 0);
    chk("t2_ready39", rdy_log[39], 1'b0);
    chk("t2_ready40", rdy_log[40], 1'b1);
    chk("t2_rx_first", rx_word, 32'hDEADBEEF);
    chk("t2_second_send", send_out, 1'b1);
    chk("t2_second_seg", seg_out, 4'hF);
    word_valid = 1'b0;
    repeat (23) tick();
    chk("t2_done", done, 1'b1);
    chk("t2_rx_second", rx_word, 32'h0000000F);
    repeat (20) tick();

    // Timeout with no acknowledge
    resp_en = 1'b0;
    word_data = 32'hA5A5A5A5; word_valid = 1'b1;
    tick();
    word_valid = 1'b0;
    dcnt = 0;
    for (int c = 1; c <= 64; c++) begin
      if (c == 1 || c == 64) begin
        chk("t3_send", send_out, 1'b1);
        chk("t3_seg", seg_out, 4'h5);
      end
      dcnt += done;
      tick();
    end
    chk("t3_terr", timeout_err, 1'b1);
    chk("t3_ready", word_ready, 1'b1);
    chk("t3_send_off", send_out, 1'b0);
    chk("t3_busy", busy, 1'b0);
    chk("t3_no_done", dcnt + done, 0);
    tick();
    chk("t3_terr_pulse", timeout_err, 1'b0);
    resp_en = 1'b1;

    // Reset mid-word, after the third ack
    word_data = 32'h0BADF00D; word_valid = 1'b1;
    tick();
    word_valid = 1'b0;
    repeat (9) tick();
    chk("t4_send_pre", send_out, 1'b1);
    chk("t4_seg_pre", seg_out, 4'hF);
    rst_n = 1'b0;
    #1;
    chk("t4_send_async", send_out, 1'b0);
    chk("t4_seg_async", seg_out, 4'h0);
    chk("t4_busy_async", busy, 1'b0);
    chk("t4_ready_async", word_ready, 1'b1);
    tick(); tick();
    rst_n = 1'b1;
    word_data = 32'hCAFEF00D; word_valid = 1'b1;
    tick();
    word_valid = 1'b0;
    repeat (23) tick();
    chk("t4_done", done, 1'b1);
    chk("t4_rx", rx_word, 32'hCAFEF00D);
    repeat (16) tick();
    chk("t4_ready", word_ready, 1'b1);

    // Spurious acks in IDLE, RELEASE and GAP
    resp_en = 1'b0;
    force_ack = 1'b1;
    tick();
    force_ack = 1'b0;
    chk("t5_idle_busy", busy, 1'b0);
    chk("t5_idle_done", done, 1'b0);
    chk("t5_idle_ready", word_ready, 1'b1);
    word_data = 32'h87654321; word_valid = 1'b1;
    tick();
    word_valid = 1'b0;
    chk("t5_seg0", seg_out, 4'h1);
    tick();
    force_ack = 1'b1;
    tick();
    chk("t5_release", send_out, 1'b0);
    tick();
    force_ack = 1'b0;
    chk("t5_send1", send_out, 1'b1);
    chk("t5_seg1", seg_out, 4'h2);
    resp_en = 1'b1;
    repeat (20) tick();
    chk("t5_done", done, 1'b1);
    tick();
    force_ack = 1'b1;
    tick();
    force_ack = 1'b0;
    chk("t5_gap_done", done, 1'b0);
    chk("t5_gap_busy", busy, 1'b1);
    chk("t5_gap_send", send_out, 1'b0);
    repeat (13) tick();
    chk("t5_ready39", word_ready, 1'b0);
    tick();
    chk("t5_ready40", word_ready, 1'b1);

    // Ack on the last cycle before timeout
    resp_en = 1'b0;
    word_data = 32'h00000003; word_valid = 1'b1;
    tick();
    word_valid = 1'b0;
    repeat (63) tick();
    chk("t6_send64", send_out, 1'b1);
    chk("t6_seg64", seg_out, 4'h3);
    force_ack = 1'b1;
    tick();
    force_ack = 1'b0;
    chk("t6_no_terr", timeout_err, 1'b0);
    chk("t6_release", send_out, 1'b0);
    chk("t6_busy", busy, 1'b1);
    tick();
    chk("t6_send_nib1", send_out, 1'b1);
    chk("t6_seg_nib1", seg_out, 4'h0);
    repeat (63) tick();
    chk("t6_send_nib1_end", send_out, 1'b1);
    tick();
    chk("t6_terr_nib1", timeout_err, 1'b1);
    chk("t6_ready", word_ready, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/nibble_insn_tx.md
# nibble_insn_tx

Host-side transmitter for the 4-bit nibble instruction link into the PCPI coprocessor tile. It accepts a 32-bit instruction word over a valid/ready port and serialises it as eight nibbles, least-significant nibble first. Each nibble goes out with a send strobe; the block waits for the tile's one-cycle acknowledge before moving on. It sits in the host/FPGA test harness, driving the tile's `ui_in[4:1]` (segment) and `ui_in[0]` (send) pins and sampling `uo_out[0]` (ack).

## Interface
- `ACK_TIMEOUT`, 64: cycles to wait for ack per nibble. 0 disables the timeout.
- `GAP_CYCLES`, 16: idle cycles forced after each word, covering the receiver's busy states while the coprocessor runs. Minimum 1.
- `clk`  in  1  clock. One clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `word_valid`  in  1  instruction word offered.
- `word_data`  in  32  instruction word; sampled on accept.
- `word_ready`  out  1  block can accept a word.
- `seg_out`  out  4  current nibble; goes to the tile's `ui_in[4:1]`.
- `send_out`  out  1  send strobe; goes to the tile's `ui_in[0]`.
- `ack_in`  in  1  receiver acknowledge; comes from the tile's `uo_out[0]`.
- `busy`  out  1  a word is in flight or in the gap.
- `done`  out  1  one-cycle pulse when the 8th nibble is acknowledged.
- `timeout_err`  out  1  one-cycle pulse when a word is aborted on timeout.

## Operation
- **States:** IDLE, SEND, RELEASE, GAP. The state is registered.
- **IDLE**
  - `word_ready`=1.
  - When `word_valid`&&`word_ready`: latch `word_data`, set idx=0, clear the timeout counter, go to SEND.
- **SEND**
  - `send_out`=1, `seg_out`=word[4*idx+:4].
  - On `ack_in`=1 with idx<7: idx+1, go to RELEASE.
  - On `ack_in`=1 with idx=7: go to GAP and pulse `done`.
  - Otherwise the timeout counter increments. When it reaches `ACK_TIMEOUT`, pulse `timeout_err` and go to IDLE. The word is discarded, the receiver is left mid-word, and the host must reset the tile.
- **RELEASE**
  - `send_out`=0 for exactly one cycle.
  - Clear the timeout counter and go to SEND.
- **GAP**
  - `send_out`=0.
  - Count `GAP_CYCLES` cycles, then go to IDLE.
- **Output derivation**
  - `seg_out` is 0 outside SEND.
  - `busy` = state≠IDLE.
  - All outputs decode from registered state, idx, and the word register.
  - There is no combinational path from `ack_in` or `word_valid` to any output.
- **Boundary rules**
  - `ack_in` is ignored in IDLE, RELEASE and GAP.
  - If ack and timeout occur in the same cycle, ack wins.
  - `word_valid` held high during a word or GAP is not accepted until IDLE.
  - idx never wraps: its only exit at 7 is to GAP.
- **Reset values** (asserted at any time, including mid-word):
  - State IDLE, idx=0, word register=0.
  - `send_out`=0, `seg_out`=0, `done`=0, `timeout_err`=0, `busy`=0, `word_ready`=1.

## Timing
- Cycle 0 is the accept edge (valid&&ready sampled).
- Nibble k is driven with `send_out` high from cycle 1+3k.
- The receiver latches at the end of cycle 1+3k and raises ack in cycle 2+3k.
- RELEASE occupies cycle 3+3k.
- Per nibble: 3 cycles, except the last, which takes 2.
- The 8th ack arrives in cycle 23 and `done` pulses in cycle 24, the first GAP cycle.
- `word_ready` returns high in cycle 24+`GAP_CYCLES`.
- `seg_out` is stable for the whole SEND dwell, including the ack cycle.
- Timeout: SEND with no ack lasts `ACK_TIMEOUT` cycles, `timeout_err` pulses on the following cycle (IDLE), and `word_ready`=1 in that same cycle.

## Structure
- Shared package `pcpi_link_pkg` holds:
  - the state enum;
  - `NIBBLE_W`=4, `NIBBLES`=8;
  - the instruction width of 32.
- The receiver tile imports the same constants.
- No sub-module; a single FSM with idx, timeout and gap counters.
- The bench pairs this block with the existing tile as a loopback responder.

## Test plan
- **Single word:** accept 0x12345678 with the tile in loopback → `seg_out` sequence 8,7,6,5,4,3,2,1; `done` in cycle 24; the tile's latched instruction = 0x12345678.
- **Back-to-back:** `word_valid` held high with 0xDEADBEEF then 0x0000000F, `GAP_CYCLES`=16 → second accept in cycle 40; no `send_out` during cycles 24–39.
- **Timeout:** `ack_in` tied 0, `ACK_TIMEOUT`=64 → SEND for 64 cycles; `timeout_err` pulse; IDLE; `done` never asserted.
- **Reset mid-word:** `rst_n` low after the 3rd ack → `send_out` and `seg_out` drop to 0 asynchronously; `busy`=0; a fresh word after release transmits correctly.
- **Spurious ack:** `ack_in` pulsed in IDLE, RELEASE and GAP → no idx change, no `done`, state unaffected.
- **Ack/timeout collision:** ack arrives on the `ACK_TIMEOUT`th cycle of SEND → ack accepted, no `timeout_err`.
